food_spawner: RTL

Upstream producer of food coordinates for the Snake game core. On request, it draws pseudo-random candidate cells from a free-running LFSR and checks each one against the block grid through a 1-cycle-latency read port. It returns the first empty interior cell. If too many random draws fail, it falls back to a deterministic raster scan, and it reports failure when the interior has no empty cell.

---
 rtl/food_spawner.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/food_spawner.sv
// food_spawner: finds an empty interior cell of the snake grid for the next food item.
// Random draws come from a free-running 16-bit Galois LFSR. Each in-range draw is checked
// against the grid through a read port with one cycle of latency. After MAX_TRIES draws
// the block falls back to a raster scan. It reports Fail if no interior cell is empty.
module food_spawner #(
  parameter int unsigned GRID_WIDTH     = 40,
  parameter int unsigned GRID_HEIGHT    = 30,
  parameter int unsigned BITS_PER_BLOCK = 2,
  parameter logic [BITS_PER_BLOCK-1:0] BLOCK_EMPTY = '0,
  parameter int unsigned MAX_TRIES      = 64,
  parameter logic [15:0] SEED           = 16'hACE1,
  localparam int unsigned WV = $clog2(GRID_HEIGHT),
  localparam int unsigned WH = $clog2(GRID_WIDTH)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Request,
  input  logic                      EntropyIn,
  output logic                      RdEn,
  output logic [WV-1:0]             RdV,
  output logic [WH-1:0]             RdH,
  input  logic [BITS_PER_BLOCK-1:0] RdData,
  output logic [WV-1:0]             FoodV,
  output logic [WH-1:0]             FoodH,
  output logic                      FoodValid,
  output logic                      Fail,
  output logic                      Busy
);

  localparam int unsigned TW          = $clog2(MAX_TRIES + 1);
  localparam logic [15:0] LFSR_MASK   = 16'hB400;
  localparam logic [15:0] LFSR_RELOAD = 16'hACE1;
  // A zero seed would lock the LFSR, so it is replaced by the standard reload value.
  localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? LFSR_RELOAD : SEED;
  localparam logic [WV-1:0] V_MIN     = WV'(1);
  localparam logic [WV-1:0] V_MAX     = WV'(GRID_HEIGHT - 2);
  localparam logic [WH-1:0] H_MIN     = WH'(1);
  localparam logic [WH-1:0] H_MAX     = WH'(GRID_WIDTH - 2);
  localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);

  // The candidate row and column fields must both fit inside the LFSR word.
  if (WV + WH > 16) begin : gCandidateWidth
    $error("food_spawner: WV+WH exceeds the 16-bit LFSR");
  end

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    READ,
    CHECK,
    SCAN_READ,
    SCAN_CHECK,
    DONE,
    FAILED
  } stateType;

  stateType          state;
  stateType          stateNext;
  logic [15:0]       lfsr;
  logic [15:0]       lfsrNext;
  logic [TW-1:0]     tries;
  logic [TW-1:0]     triesNext;
  logic [TW-1:0]     triesInc;
  logic [WV-1:0]     candV;
  logic [WV-1:0]     candVNext;
  logic [WH-1:0]     candH;
  logic [WH-1:0]     candHNext;
  logic [WV-1:0]     curV;
  logic [WV-1:0]     curVNext;
  logic [WH-1:0]     curH;
  logic [WH-1:0]     curHNext;
  logic [WV-1:0]     drawV;
  logic [WH-1:0]     drawH;
  logic [WV-1:0]     foodVNext;
  logic [WH-1:0]     foodHNext;
  logic [WV-1:0]     rdVNext;
  logic [WH-1:0]     rdHNext;
  logic              rdEnNext;
  logic              busyNext;
  logic              foodValidNext;
  logic              failNext;
  logic              drawInRange;
  logic              cellEmpty;
  logic              drawExhausted;
  logic              triesExhausted;

  // Galois step with entropy folded into bit 0; a zero state is recovered next cycle.
  always_comb begin
    lfsrNext    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    lfsrNext[0] = lfsrNext[0] ^ EntropyIn;
    if (lfsr == 16'h0000) begin
      lfsrNext = LFSR_RELOAD;
    end
  end

  // Candidate decode and the conditions the FSM branches on.
  always_comb begin
    drawV          = lfsr[WV-1:0];
    drawH          = lfsr[WV+WH-1:WV];
    drawInRange    = (drawV >= V_MIN) && (drawV <= V_MAX) &&
                     (drawH >= H_MIN) && (drawH <= H_MAX);
    cellEmpty      = (RdData == BLOCK_EMPTY);
    triesInc       = tries + TW'(1);
    drawExhausted  = (triesInc == TRIES_MAX);
    triesExhausted = (tries == TRIES_MAX);
  end

  // Next-state, datapath and next-output logic.
  always_comb begin
    stateNext = state;
    triesNext = tries;
    candVNext = candV;
    candHNext = candH;
    curVNext  = curV;
    curHNext  = curH;
    foodVNext = FoodV;
    foodHNext = FoodH;

    case (state)
      IDLE: begin
        if (Request) begin
          triesNext = '0;
          stateNext = DRAW;
        end
      end

      DRAW: begin
        candVNext = drawV;
        candHNext = drawH;
        triesNext = triesInc;
        if (drawInRange) begin
          stateNext = READ;
        end else if (drawExhausted) begin
          curVNext  = V_MIN;
          curHNext  = H_MIN;
          stateNext = SCAN_READ;
        end
      end

      READ: begin
        stateNext = CHECK;
      end

      CHECK: begin
        if (cellEmpty) begin
          foodVNext = candV;
          foodHNext = candH;
          stateNext = DONE;
        end else if (triesExhausted) begin
          curVNext  = V_MIN;
          curHNext  = H_MIN;
          stateNext = SCAN_READ;
        end else begin
          stateNext = DRAW;
        end
      end

      SCAN_READ: begin
        stateNext = SCAN_CHECK;
      end

      SCAN_CHECK: begin
        if (cellEmpty) begin
          foodVNext = curV;
          foodHNext = curH;
          stateNext = DONE;
        end else if (curH == H_MAX) begin
          if (curV == V_MAX) begin
            stateNext = FAILED;
          end else begin
            curHNext  = H_MIN;
            curVNext  = curV + WV'(1);
            stateNext = SCAN_READ;
          end
        end else begin
          curHNext  = curH + WH'(1);
          stateNext = SCAN_READ;
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      FAILED: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    rdEnNext      = 1'b0;
    rdVNext       = '0;
    rdHNext       = '0;
    busyNext      = 1'b0;
    foodValidNext = 1'b0;
    failNext      = 1'b0;

    case (stateNext)
      READ: begin
        rdEnNext = 1'b1;
        rdVNext  = candVNext;
        rdHNext  = candHNext;
        busyNext = 1'b1;
      end
      SCAN_READ: begin
        rdEnNext = 1'b1;
        rdVNext  = curVNext;
        rdHNext  = curHNext;
        busyNext = 1'b1;
      end
      DRAW, CHECK, SCAN_CHECK: begin
        busyNext = 1'b1;
      end
      DONE: begin
        foodValidNext = 1'b1;
      end
      FAILED: begin
        failNext = 1'b1;
      end
      default: begin
        busyNext = 1'b0;
      end
    endcase
  end

  // State register; the LFSR keeps running in every state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      lfsr  <= SEED_EFF;
      tries <= '0;
      candV <= '0;
      candH <= '0;
      curV  <= '0;
      curH  <= '0;
    end else begin
      state <= stateNext;
      lfsr  <= lfsrNext;
      tries <= triesNext;
      candV <= candVNext;
      candH <= candHNext;
      curV  <= curVNext;
      curH  <= curHNext;
    end
  end

  // Registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      RdEn      <= 1'b0;
      RdV       <= '0;
      RdH       <= '0;
      FoodV     <= '0;
      FoodH     <= '0;
      FoodValid <= 1'b0;
      Fail      <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      RdEn      <= rdEnNext;
      RdV       <= rdVNext;
      RdH       <= rdHNext;
      FoodV     <= foodVNext;
      FoodH     <= foodHNext;
      FoodValid <= foodValidNext;
      Fail      <= failNext;
      Busy      <= busyNext;
    end
  end

endmodule
